uart_rx_fifo: RTL and testbench

Receive-side byte buffer sitting directly downstream of `uart_rx`. It captures each byte `uart_rx` presents on `data_out` when `ready` rises and stores it in a circular FIFO. Consumer logic (command parser, loopback to `uart_tx`) drains the FIFO through a first-word-fall-through valid/accept handshake. Overruns are reported with a sticky flag.

---
 rtl/uart_rx_fifo.sv | 106 ++++++++++
 tb/tb_uart_rx_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_rx: edge-detects rx_ready, buffers bytes,
// and drains through a first-word-fall-through valid/accept handshake.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_accept,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  rx_ready_q, rx_ready_d;

    logic push_req;
    logic push;
    logic pop;
    logic full_int;
    logic valid_int;

    assign full_int  = (count_q == CNT_WIDTH'(DEPTH));
    assign valid_int = (count_q != '0);
    assign push_req  = rx_ready & ~rx_ready_q;
    assign pop       = valid_int & rd_accept;
    // A full FIFO still takes a byte if the head leaves in the same cycle.
    assign push      = push_req & (~full_int | pop);

    always_comb begin
        rx_ready_d = rx_ready;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        // Dropping a byte wins over a same-cycle clear.
        if (push_req & ~push) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_q <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = valid_int;
    assign full     = full_int;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs change on the falling edge,
// outputs are sampled on the falling edge after the active rising edge.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_accept;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       clr_overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] vartex [6] = '{8'h56, 8'h41, 8'h52, 8'h54, 8'h45, 8'h58};

    uart_rx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_accept    (rd_accept),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic push_byte(input logic [7:0] d);
        rx_data  = d;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_ready = 1'b1; rx_data = 8'h99;
        rd_accept = 1'b0; clr_overflow = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rx_ready = 1'b0;
        @(negedge clk);
        push_byte(8'h11);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL reset_repush_count: got %0d want 1", count); end
        n_cmp++; if (rd_data !== 8'h11) begin n_err++; $display("FAIL reset_repush_data: got %h want 11", rd_data); end
        rd_accept = 1'b1; @(negedge clk); rd_accept = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_pop_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_vartex();
        for (int i = 0; i < 6; i++) begin
            push_byte(vartex[i]);
            repeat (3) @(negedge clk);
        end
        n_cmp++; if (count !== 5'd6) begin n_err++; $display("FAIL vartex_count: got %0d want 6", count); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== vartex[i]) begin
                n_err++; $display("FAIL vartex_pop%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, vartex[i]);
            end
            rd_accept = 1'b1; @(negedge clk); rd_accept = 1'b0;
        end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL vartex_end_valid: got %b want 0", rd_valid); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL vartex_end_count: got %0d want 0", count); end
    endtask

    task automatic test_level();
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL level_count: got %0d want 1", count); end
        n_cmp++; if (rd_data !== 8'hA5) begin n_err++; $display("FAIL level_data: got %h want a5", rd_data); end
        rd_accept = 1'b1; @(negedge clk); rd_accept = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL level_drain: got %0d want 0", count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        n_cmp++; if (count !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL ovf_fill: got c=%0d f=%b want c=16 f=1", count, full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_fill_flag: got %b want 0", overflow); end
        push_byte(8'h10);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_cmp++; if (count !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL ovf_count: got c=%0d f=%b want c=16 f=1", count, full); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL ovf_head: got %h want 00", rd_data); end
        clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        // Drop and clear in the same cycle: the set must win.
        rx_data = 8'h10; rx_ready = 1'b1; clr_overflow = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; clr_overflow = 1'b0;
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_priority: got %b want 1", overflow); end
        clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear2: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        rx_data = 8'h20; rx_ready = 1'b1; rd_accept = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; rd_accept = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
        n_cmp++; if (count !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL fpp_count: got c=%0d f=%b want c=16 f=1", count, full); end
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] exp;
            exp = (i == 16) ? 8'h20 : 8'(i);
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                n_err++; $display("FAIL fpp_drain%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, exp);
            end
            rd_accept = 1'b1; @(negedge clk); rd_accept = 1'b0;
        end
        n_cmp++; if (rd_valid !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL fpp_empty: got v=%b c=%0d want v=0 c=0", rd_valid, count); end
    endtask

    task automatic test_empty_and_reset();
        rd_accept = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (count !== 5'd0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_accept: got c=%0d v=%b want c=0 v=0", count, rd_valid); end
        rx_data = 8'h33; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; rd_accept = 1'b0;
        n_cmp++; if (count !== 5'd1 || rd_valid !== 1'b1) begin n_err++; $display("FAIL empty_pushpop: got c=%0d v=%b want c=1 v=1", count, rd_valid); end
        n_cmp++; if (rd_data !== 8'h33) begin n_err++; $display("FAIL empty_pushpop_data: got %h want 33", rd_data); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (count !== 5'd0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL async_reset: got c=%0d v=%b want c=0 v=0", count, rd_valid); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_byte(8'h44);
        n_cmp++; if (count !== 5'd1 || rd_data !== 8'h44) begin n_err++; $display("FAIL post_reset_push: got c=%0d d=%h want c=1 d=44", count, rd_data); end
    endtask

    initial begin
        test_reset();
        test_vartex();
        test_level();
        test_overflow();
        test_full_push_pop();
        test_empty_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
